nvram_arbiter: RTL and testbench

Shares the single-port CMOS high-score/settings RAM between the game CPU and the HPS ioctl channel (NVRAM load on index 4, NVRAM save via upload). The CPU always wins a cycle; HPS transfers are serviced in gaps and throttled with `ioctl_wait`. The block sits beside the game core in the `clk_sys` domain, between `hps_io` and the CMOS RAM, and tracks a dirty flag so the frontend knows when a save is needed.

---
 rtl/nvram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_nvram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_arbiter.sv
// nvram_arbiter: shares the single-port CMOS RAM between the game CPU and the
// HPS ioctl channel. The CPU always wins a cycle. HPS loads and saves are
// serviced in the gaps and throttled with ioctl_wait. A dirty flag tells the
// frontend that the CPU has changed the RAM since the last save.
module nvram_arbiter #(
   parameter int AW = 8,
   parameter int DW = 4
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_rdy,
   input  logic          nvram_sel,
   input  logic          ioctl_download,
   input  logic          ioctl_upload,
   input  logic          ioctl_wr,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          nvram_dirty
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t          state_reg;
   logic            rd_owner_cpu_reg;
   logic            cpu_pend_reg;
   logic            cpu_pend_we_reg;
   logic [AW-1:0]   cpu_pend_addr_reg;
   logic [DW-1:0]   cpu_pend_din_reg;
   logic            hps_pend_reg;
   logic            hps_we_reg;
   logic            hps_oor_reg;
   logic [AW-1:0]   hps_addr_reg;
   logic [DW-1:0]   hps_data_reg;
   logic            upload_q_reg;
   logic            cpu_rdy_reg;
   logic            dirty_reg;
   logic [DW-1:0]   cpu_dout_reg;
   logic [7:0]      ioctl_din_reg;

   logic            hps_strobe;
   logic            grant_cpu;
   logic            grant_hps;
   logic            cpu_g_we;
   logic [AW-1:0]   cpu_g_addr;
   logic [DW-1:0]   cpu_g_din;
   logic            cpu_wr_block;
   logic            cpu_wr_done;
   logic            upload_fall;
   logic [7:0]      rd_pack;

   assign hps_strobe  = nvram_sel & ((ioctl_wr & ioctl_download) | (ioctl_rd & ioctl_upload));
   assign upload_fall = upload_q_reg & ~ioctl_upload & nvram_sel;
   assign cpu_wr_block = ioctl_download & nvram_sel;

   // Grant decision and the RAM port it drives; a pending CPU access replays its latched fields
   always_comb begin
      cpu_g_we    = cpu_pend_reg ? cpu_pend_we_reg   : cpu_we;
      cpu_g_addr  = cpu_pend_reg ? cpu_pend_addr_reg : cpu_addr;
      cpu_g_din   = cpu_pend_reg ? cpu_pend_din_reg  : cpu_din;
      grant_cpu   = (state_reg == IDLE) & (cpu_req | cpu_pend_reg);
      grant_hps   = (state_reg == IDLE) & ~grant_cpu & hps_pend_reg;
      cpu_wr_done = grant_cpu & cpu_g_we & ~cpu_wr_block;
      if (grant_cpu) begin
         ram_addr = cpu_g_addr;
         ram_din  = cpu_g_din;
         ram_we   = cpu_wr_done;
      end else begin
         ram_addr = hps_addr_reg;
         ram_din  = hps_data_reg;
         ram_we   = grant_hps & hps_we_reg & ~hps_oor_reg;
      end
      // HPS reads see the narrow RAM word padded with ones in the upper bits
      rd_pack            = 8'hFF;
      rd_pack[DW-1:0]    = ram_dout;
   end

   // Pending requests, arbitration FSM, read capture and dirty tracking
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_reg         <= IDLE;
         rd_owner_cpu_reg  <= 1'b0;
         cpu_pend_reg      <= 1'b0;
         cpu_pend_we_reg   <= 1'b0;
         cpu_pend_addr_reg <= '0;
         cpu_pend_din_reg  <= '0;
         hps_pend_reg      <= 1'b0;
         hps_we_reg        <= 1'b0;
         hps_oor_reg       <= 1'b0;
         hps_addr_reg      <= '0;
         hps_data_reg      <= '0;
         upload_q_reg      <= 1'b0;
         cpu_rdy_reg       <= 1'b0;
         dirty_reg         <= 1'b0;
         cpu_dout_reg      <= '0;
         ioctl_din_reg     <= 8'h00;
      end else begin
         cpu_rdy_reg  <= 1'b0;
         upload_q_reg <= ioctl_upload;

         if (grant_cpu) begin
            cpu_pend_reg <= 1'b0;
         end else if (cpu_req) begin
            cpu_pend_reg      <= 1'b1;
            cpu_pend_we_reg   <= cpu_we;
            cpu_pend_addr_reg <= cpu_addr;
            cpu_pend_din_reg  <= cpu_din;
         end

         // An HPS write retires at its grant, a read only once its data is captured
         if (hps_strobe && !hps_pend_reg) begin
            hps_pend_reg <= 1'b1;
            hps_we_reg   <= ioctl_wr & ioctl_download;
            hps_oor_reg  <= (ioctl_addr[24:AW] != '0);
            hps_addr_reg <= ioctl_addr[AW-1:0];
            hps_data_reg <= ioctl_dout[DW-1:0];
         end else if ((grant_hps && hps_we_reg) ||
                      (state_reg == RD_WAIT && !rd_owner_cpu_reg)) begin
            hps_pend_reg <= 1'b0;
         end

         // A CPU write in the same cycle as the save completing keeps the flag set
         if (cpu_wr_done) begin
            dirty_reg <= 1'b1;
         end else if (upload_fall) begin
            dirty_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (grant_cpu) begin
                  if (cpu_g_we) begin
                     cpu_rdy_reg <= 1'b1;
                  end else begin
                     state_reg        <= RD_WAIT;
                     rd_owner_cpu_reg <= 1'b1;
                  end
               end else if (grant_hps && !hps_we_reg) begin
                  state_reg        <= RD_WAIT;
                  rd_owner_cpu_reg <= 1'b0;
               end
            end
            RD_WAIT: begin
               state_reg <= IDLE;
               if (rd_owner_cpu_reg) begin
                  cpu_dout_reg <= ram_dout;
                  cpu_rdy_reg  <= 1'b1;
               end else begin
                  ioctl_din_reg <= hps_oor_reg ? 8'hFF : rd_pack;
               end
            end
         endcase
      end
   end

   assign cpu_dout    = cpu_dout_reg;
   assign cpu_rdy     = cpu_rdy_reg;
   assign ioctl_din   = ioctl_din_reg;
   assign ioctl_wait  = hps_pend_reg;
   assign nvram_dirty = dirty_reg;

endmodule

// File: tb/tb_nvram_arbiter.sv
// Self-checking bench for nvram_arbiter: a behavioural RAM beside the DUT and
// a plain array holding the expected contents of every location.
module tb_nvram_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_addr = 8'h00;
   logic [3:0]  cpu_din = 4'h0;
   logic [3:0]  cpu_dout;
   logic        cpu_rdy;
   logic        nvram_sel = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_upload = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = 25'h0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [3:0]  ram_din;
   logic [3:0]  ram_dout;
   logic        nvram_dirty;

   int checks = 0;
   int failures = 0;

   logic [3:0] ram_mem [256];
   logic [3:0] model [256];

   nvram_arbiter #(.AW(8), .DW(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
      .nvram_sel(nvram_sel), .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
      .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .nvram_dirty(nvram_dirty)
   );

   always #5 clk_sys = ~clk_sys;

   // Synchronous-read CMOS RAM
   always @(posedge clk_sys) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   // Advance to just after the next active edge (drive point)
   task automatic cyc;
      @(posedge clk_sys);
      #1;
   endtask

   // Mid-cycle sample point
   task automatic mid;
      @(negedge clk_sys);
   endtask

   task automatic do_cpu_write(input logic [7:0] a, input logic [3:0] d, input logic supp);
      cyc; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d; mid;
      checks++; if (ram_we !== !supp) begin failures++; $display("FAIL cpu_wr_we got=%b exp=%b", ram_we, !supp); end
      if (!supp) begin
         checks++; if (ram_addr !== a || ram_din !== d) begin failures++; $display("FAIL cpu_wr_port got=%h/%h exp=%h/%h", ram_addr, ram_din, a, d); end
         model[a] = d;
      end
      cyc; cpu_req = 1'b0; mid;
      checks++; if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL cpu_wr_rdy got=%b exp=1", cpu_rdy); end
      repeat (2) cyc;
   endtask

   task automatic do_cpu_read(input logic [7:0] a);
      cyc; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; mid;
      checks++; if (ram_we !== 1'b0 || ram_addr !== a) begin failures++; $display("FAIL cpu_rd_port got=%b/%h exp=0/%h", ram_we, ram_addr, a); end
      cyc; cpu_req = 1'b0; mid;
      checks++; if (cpu_rdy !== 1'b0) begin failures++; $display("FAIL cpu_rd_early_rdy got=%b exp=0", cpu_rdy); end
      cyc; mid;
      checks++; if (cpu_rdy !== 1'b1 || cpu_dout !== model[a]) begin failures++; $display("FAIL cpu_rd_data addr=%h got=%b/%h exp=1/%h", a, cpu_rdy, cpu_dout, model[a]); end
      cyc;
   endtask

   task automatic do_hps_write(input logic [24:0] a, input logic [7:0] d);
      logic inr;
      inr = (a < 25'd256);
      cyc; nvram_sel = 1'b1; ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; mid;
      cyc; ioctl_wr = 1'b0; mid;
      checks++; if (ioctl_wait !== 1'b1 || ram_we !== inr) begin failures++; $display("FAIL hps_wr_grant addr=%h got=%b/%b exp=1/%b", a, ioctl_wait, ram_we, inr); end
      if (inr) begin
         checks++; if (ram_addr !== a[7:0] || ram_din !== d[3:0]) begin failures++; $display("FAIL hps_wr_port got=%h/%h exp=%h/%h", ram_addr, ram_din, a[7:0], d[3:0]); end
         model[a[7:0]] = d[3:0];
      end
      cyc; mid;
      checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL hps_wr_wait_drop got=%b exp=0", ioctl_wait); end
   endtask

   task automatic do_hps_read(input logic [24:0] a);
      logic [7:0] exp_d;
      exp_d = (a < 25'd256) ? (8'hF0 | {4'h0, model[a[7:0]]}) : 8'hFF;
      cyc; nvram_sel = 1'b1; ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = a; mid;
      cyc; ioctl_rd = 1'b0; mid;
      checks++; if (ioctl_wait !== 1'b1 || ram_we !== 1'b0) begin failures++; $display("FAIL hps_rd_grant got=%b/%b exp=1/0", ioctl_wait, ram_we); end
      cyc; mid;
      checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL hps_rd_wait_hold got=%b exp=1", ioctl_wait); end
      cyc; mid;
      checks++; if (ioctl_wait !== 1'b0 || ioctl_din !== exp_d) begin failures++; $display("FAIL hps_rd_data addr=%h got=%b/%h exp=0/%h", a, ioctl_wait, ioctl_din, exp_d); end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) cyc;
      mid;
      checks++; if (cpu_rdy !== 1'b0 || ioctl_wait !== 1'b0 || nvram_dirty !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", cpu_rdy, ioctl_wait, nvram_dirty); end
      checks++; if (cpu_dout !== 4'h0 || ioctl_din !== 8'h00 || ram_we !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%h/%b exp=0/00/0", cpu_dout, ioctl_din, ram_we); end
      cyc; reset_n = 1'b1;
   endtask

   task automatic test_cpu_write_read;
      do_cpu_write(8'h12, 4'hA, 1'b0);
      do_cpu_read(8'h12);
      mid;
      checks++; if (nvram_dirty !== 1'b1) begin failures++; $display("FAIL cpu_dirty_set got=%b exp=1", nvram_dirty); end
   endtask

   task automatic test_download_upload;
      for (int i = 0; i < 256; i++) do_hps_write(25'(i), 8'hF0 | 8'(i));
      ioctl_download = 1'b0;
      for (int i = 0; i < 256; i++) do_hps_read(25'(i));
      cyc; ioctl_upload = 1'b0;
      cyc; mid;
      checks++; if (nvram_dirty !== 1'b0) begin failures++; $display("FAIL upload_clears_dirty got=%b exp=0", nvram_dirty); end
   endtask

   task automatic test_collision;
      cyc; nvram_sel = 1'b1; ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'h05; ioctl_dout = 8'h33; mid;
      cyc; ioctl_wr = 1'b0; ioctl_download = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h06; cpu_din = 4'h9; mid;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h06 || ram_din !== 4'h9) begin failures++; $display("FAIL coll_cpu_first got=%b/%h/%h exp=1/06/9", ram_we, ram_addr, ram_din); end
      cyc; cpu_req = 1'b0; mid;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h05 || ram_din !== 4'h3) begin failures++; $display("FAIL coll_hps_next got=%b/%h/%h exp=1/05/3", ram_we, ram_addr, ram_din); end
      checks++; if (ioctl_wait !== 1'b1 || cpu_rdy !== 1'b1) begin failures++; $display("FAIL coll_wait_rdy got=%b/%b exp=1/1", ioctl_wait, cpu_rdy); end
      cyc; mid;
      checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL coll_wait_drop got=%b exp=0", ioctl_wait); end
      model[6] = 4'h9; model[5] = 4'h3;
      repeat (2) cyc;
   endtask

   task automatic test_suppress;
      cyc; nvram_sel = 1'b1; ioctl_upload = 1'b1;
      cyc; ioctl_upload = 1'b0;
      cyc; cyc; mid;
      checks++; if (nvram_dirty !== 1'b0) begin failures++; $display("FAIL supp_pre_clear got=%b exp=0", nvram_dirty); end
      ioctl_download = 1'b1;
      do_cpu_write(8'h00, 4'h7, 1'b1);
      mid;
      checks++; if (nvram_dirty !== 1'b0) begin failures++; $display("FAIL supp_dirty got=%b exp=0", nvram_dirty); end
      do_hps_write(25'h100, 8'h5C);
      do_hps_read(25'h100);
      ioctl_upload = 1'b0; ioctl_download = 1'b0;
      do_cpu_read(8'h00);
   endtask

   task automatic test_dirty;
      do_cpu_write(8'h40, 4'h5, 1'b0);
      // upload pulse with nvram_sel low must not clear
      cyc; nvram_sel = 1'b0; ioctl_upload = 1'b1;
      cyc; ioctl_upload = 1'b0;
      cyc; mid;
      checks++; if (nvram_dirty !== 1'b1) begin failures++; $display("FAIL dirty_needs_sel got=%b exp=1", nvram_dirty); end
      // set and clear in the same cycle: set wins
      cyc; nvram_sel = 1'b1; ioctl_upload = 1'b1;
      cyc; ioctl_upload = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h41; cpu_din = 4'h6; mid;
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL dirty_coincide_we got=%b exp=1", ram_we); end
      cyc; cpu_req = 1'b0; mid;
      checks++; if (nvram_dirty !== 1'b1 || cpu_rdy !== 1'b1) begin failures++; $display("FAIL dirty_set_wins got=%b/%b exp=1/1", nvram_dirty, cpu_rdy); end
      model[8'h41] = 4'h6;
      cyc; ioctl_upload = 1'b1;
      cyc; ioctl_upload = 1'b0;
      cyc; mid;
      checks++; if (nvram_dirty !== 1'b0) begin failures++; $display("FAIL dirty_clear got=%b exp=0", nvram_dirty); end
      nvram_sel = 1'b0;
      repeat (2) cyc;
   endtask

   task automatic test_cpu_blocked;
      logic [7:0] exp_h;
      exp_h = 8'hF0 | {4'h0, model[8'h12]};
      cyc; nvram_sel = 1'b1; ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'h12; mid;
      cyc; ioctl_rd = 1'b0; mid;
      cyc; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20; mid;
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL blk_rdwait_idle got=%b exp=0", ram_we); end
      cyc; cpu_req = 1'b0; mid;
      checks++; if (ram_addr !== 8'h20 || ioctl_wait !== 1'b0 || ioctl_din !== exp_h) begin failures++; $display("FAIL blk_pend_grant got=%h/%b/%h exp=20/0/%h", ram_addr, ioctl_wait, ioctl_din, exp_h); end
      cyc; mid;
      checks++; if (cpu_rdy !== 1'b0) begin failures++; $display("FAIL blk_rdy_early got=%b exp=0", cpu_rdy); end
      cyc; mid;
      checks++; if (cpu_rdy !== 1'b1 || cpu_dout !== model[8'h20]) begin failures++; $display("FAIL blk_rdy_data got=%b/%h exp=1/%h", cpu_rdy, cpu_dout, model[8'h20]); end
      ioctl_upload = 1'b0; nvram_sel = 1'b0;
      repeat (2) cyc;
   endtask

   task automatic test_reset_midread;
      cyc; nvram_sel = 1'b1; ioctl_upload = 1'b1; ioctl_rd = 1'b1; ioctl_addr = 25'h03; mid;
      cyc; ioctl_rd = 1'b0; mid;
      cyc; mid;
      checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL rst_pre_wait got=%b exp=1", ioctl_wait); end
      reset_n = 1'b0;
      #1;
      checks++; if (ioctl_wait !== 1'b0 || ioctl_din !== 8'h00 || cpu_rdy !== 1'b0) begin failures++; $display("FAIL rst_async got=%b/%h/%b exp=0/00/0", ioctl_wait, ioctl_din, cpu_rdy); end
      ioctl_upload = 1'b0; nvram_sel = 1'b0;
      cyc; cyc; reset_n = 1'b1;
      do_cpu_read(8'h03);
      do_hps_read(25'h04);
      ioctl_upload = 1'b0; nvram_sel = 1'b0;
   endtask

   task automatic test_random;
      for (int n = 0; n < 150; n++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom);
         case ($urandom_range(0, 3))
            0: do_cpu_write(a, d[3:0], 1'b0);
            1: do_cpu_read(a);
            2: begin do_hps_write({17'h0, a}, d); ioctl_download = 1'b0; nvram_sel = 1'b0; end
            default: begin do_hps_read({17'h0, a}); ioctl_upload = 1'b0; nvram_sel = 1'b0; end
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 4'h0;
         model[i] = 4'h0;
      end
      test_reset;
      test_cpu_write_read;
      test_download_upload;
      test_collision;
      test_suppress;
      test_dirty;
      test_cpu_blocked;
      test_reset_midread;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
